btn_debounce: RTL and testbench

- Input-side counterpart of the LED output path: conditions a raw, asynchronous, bouncing pushbutton into clean, clock-synchronous control signals.
- Sits between a board button pin and user logic, in the clk_core output domain (clk).
- Provides a debounced level, single-cycle press and release strobes, and a single-cycle long-press strobe.

---
 rtl/btn_debounce.sv | 130 +++++++++++++
 tb/tb_btn_debounce.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - pushbutton conditioner: 2-flop sync, debounce FSM, press/release/long-press strobes
// All outputs are registered; strobes are single-cycle pulses.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter bit ACTIVE_LOW        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          s1, s2;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          level_n, press_n, release_n, long_n;
  logic          btn_raw;

  // Normalise polarity before the synchronizer so reset loads "not pressed".
  assign btn_raw = btn_in ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dcnt        <= '0;
      hcnt        <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      state       <= state_n;
      dcnt        <= dcnt_n;
      hcnt        <= hcnt_n;
      btn_level   <= level_n;
      btn_press   <= press_n;
      btn_release <= release_n;
      btn_long    <= long_n;
    end
  end

  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    hcnt_n    = hcnt;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    case (state)
      IDLE: begin
        level_n = 1'b0;
        if (s2) begin
          state_n = PRESS_WAIT;
          dcnt_n  = DW'(1);
        end else begin
          dcnt_n  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_n = IDLE;
          dcnt_n  = '0;
        end else if (dcnt == D_LAST) begin
          state_n = PRESSED;
          level_n = 1'b1;
          press_n = 1'b1;
          hcnt_n  = '0;
          dcnt_n  = '0;
        end else begin
          dcnt_n  = dcnt + DW'(1);
        end
      end
      PRESSED: begin
        // Threshold is judged on the current hcnt, so a release in the same
        // cycle still yields the long strobe; saturation prevents repeats.
        if (hcnt < H_MAX) hcnt_n = hcnt + HW'(1);
        if (hcnt == H_LAST) long_n = 1'b1;
        if (!s2) begin
          state_n = RELEASE_WAIT;
          dcnt_n  = DW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_n = PRESSED;
          dcnt_n  = '0;
        end else if (dcnt == D_LAST) begin
          state_n   = IDLE;
          level_n   = 1'b0;
          release_n = 1'b1;
          hcnt_n    = '0;
          dcnt_n    = '0;
        end else begin
          dcnt_n    = dcnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed bench for btn_debounce (active-high and active-low instances)
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst;
  logic btn, btn_al;
  logic lvl, prs, rel, lng;
  logic lvl2, prs2, rel2, lng2;
  int   nvec = 0;
  int   nerr = 0;
  logic [17:0] bounce_pat;

  always #5 clk = ~clk;

  btn_debounce #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_long(lng)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .btn_in(btn_al),
    .btn_level(lvl2), .btn_press(prs2), .btn_release(rel2), .btn_long(lng2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b1; btn_al = 1'b1;

    // 1: reset with button held, then fresh press after release of reset
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_level", lvl, 1'b0);
      chk("rst_press", prs, 1'b0);
      chk("rst_release", rel, 1'b0);
      chk("rst_long", lng, 1'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk("t1_nopress", prs, 1'b0);
      chk("t1_lvl_low", lvl, 1'b0);
    end
    tick(1);
    chk("t1_press", prs, 1'b1);
    chk("t1_level", lvl, 1'b1);
    chk("t1_al_idle", lvl2, 1'b0);
    tick(1);
    chk("t1_press_1cyc", prs, 1'b0);
    btn = 1'b0;
    tick(6);
    chk("t1_release", rel, 1'b1);
    chk("t1_rel_level", lvl, 1'b0);
    tick(1);
    chk("t1_release_1cyc", rel, 1'b0);
    tick(3);

    // 2: clean press, long strobe at +26, no repeat
    btn = 1'b1;
    tick(5);
    chk("t2_nopress_p5", prs, 1'b0);
    tick(1);
    chk("t2_press_p6", prs, 1'b1);
    tick(1);
    chk("t2_press_off", prs, 1'b0);
    for (int i = 8; i <= 25; i++) begin
      tick(1);
      chk("t2_nolong_early", lng, 1'b0);
    end
    tick(1);
    chk("t2_long_p26", lng, 1'b1);
    for (int i = 27; i <= 40; i++) begin
      tick(1);
      chk("t2_nolong_late", lng, 1'b0);
      chk("t2_level_held", lvl, 1'b1);
    end
    btn = 1'b0;
    tick(6);
    chk("t2_release", rel, 1'b1);
    tick(3);

    // 3: bounce shorter than the debounce window is ignored
    bounce_pat = 18'b000000000000110111;
    for (int i = 0; i < 18; i++) begin
      btn = bounce_pat[i];
      tick(1);
      chk("t3_level", lvl, 1'b0);
      chk("t3_press", prs, 1'b0);
      chk("t3_release", rel, 1'b0);
    end

    // 4: release with bounce from PRESSED at hcnt=10
    btn = 1'b1;
    tick(6);
    chk("t4_press", prs, 1'b1);
    tick(10);
    btn = 1'b0;
    tick(1); chk("t4_nolong_a", lng, 1'b0);
    tick(1); chk("t4_nolong_b", lng, 1'b0);
    btn = 1'b1;
    tick(1); chk("t4_nolong_c", lng, 1'b0);
    btn = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk("t4_norel_early", rel, 1'b0);
      chk("t4_level_held", lvl, 1'b1);
      chk("t4_nolong", lng, 1'b0);
    end
    tick(1);
    chk("t4_release_p6", rel, 1'b1);
    chk("t4_level_low", lvl, 1'b0);
    chk("t4_nolong_rel", lng, 1'b0);
    tick(1);
    chk("t4_release_off", rel, 1'b0);
    tick(3);

    // 5: reset in the middle of a press debounce
    btn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("t5_nopress_pre", prs, 1'b0);
    end
    rst = 1'b1;
    tick(1);
    chk("t5_rst_press", prs, 1'b0);
    chk("t5_rst_level", lvl, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk("t5_nopress_post", prs, 1'b0);
    end
    tick(1);
    chk("t5_press_p6", prs, 1'b1);
    btn = 1'b0;
    tick(6);
    chk("t5_release", rel, 1'b1);
    tick(3);

    // 6: active-low instance
    btn_al = 1'b0;
    tick(5);
    chk("t6_nopress_p5", prs2, 1'b0);
    tick(1);
    chk("t6_press_p6", prs2, 1'b1);
    chk("t6_level_hi", lvl2, 1'b1);
    tick(1);
    chk("t6_press_off", prs2, 1'b0);
    btn_al = 1'b1;
    tick(5);
    chk("t6_norel_p5", rel2, 1'b0);
    tick(1);
    chk("t6_release_p6", rel2, 1'b1);
    chk("t6_level_lo", lvl2, 1'b0);
    chk("t6_nolong", lng2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
